// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit, instruction register and decoder.
package instruction_fetch_unit_pkg;

  // Instruction word field slices
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int DA_HI  = 11;
  localparam int DA_LO  = 8;
  localparam int AA_HI  = 7;
  localparam int AA_LO  = 4;
  localparam int BA_HI  = 3;
  localparam int BA_LO  = 0;

  localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

  // Fetch sequencer state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter: resets to RESET_PC, load wins over increment, wraps modulo 2^ADDR_W.
module instruction_fetch_unit_program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: a redirect overrides the sequential increment
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // PC register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: requests words from program memory, hands them to the
// instruction register with a one-cycle IL strobe, and waits for execute completion.
//
// state | meaning
// IDLE  | waiting for run
// REQ   | mem_req high, address held, waiting for mem_ack (timeout counted)
// ISSUE | IL high for one cycle, IR valid; HALT opcode checked here
// EXEC  | waiting for exec_done, then refetch or go idle
// HALT  | terminal after HALT opcode or memory timeout; left only by reset
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15,
  parameter logic [3:0]        HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [15:0]       IR,
  output logic              IL,
  output logic [ADDR_W-1:0] PC,
  output logic              halted,
  output logic              fault
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic              flush_q, flush_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              pc_ld;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_cur;
  logic [ADDR_W-1:0] next_fetch;

  // A redirect arriving in the same cycle as a fetch launch takes effect immediately
  assign next_fetch = pc_load ? pc_in : pc_cur;
  assign pc_ld      = pc_load && (state_q != ST_HALT);

  instruction_fetch_unit_program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (pc_ld),
    .load_val_i (pc_in),
    .inc_i      (pc_inc),
    .pc_o       (pc_cur)
  );

  // Sequencer next-state, fetch address, IR capture, flush and timeout
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    flush_d  = flush_q;
    tmo_d    = tmo_q;
    pc_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          addr_d  = next_fetch;
          tmo_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          tmo_d = '0;
          if (flush_q || pc_load) begin
            // stale word: drop it and relaunch at the redirected PC
            flush_d = 1'b0;
            addr_d  = next_fetch;
          end else begin
            ir_d    = mem_data;
            pc_inc  = 1'b1;
            state_d = ST_ISSUE;
          end
        end else begin
          // outstanding transfer still completes at the old address
          if (pc_load) begin
            flush_d = 1'b1;
          end
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (opcode_of(ir_q) == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (run) begin
            addr_d  = next_fetch;
            tmo_d   = '0;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= RESET_PC;
      ir_q     <= 16'h0000;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      flush_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      flush_q  <= flush_d;
      tmo_q    <= tmo_d;
    end
  end

  assign mem_req  = (state_q == ST_REQ);
  assign IL       = (state_q == ST_ISSUE);
  assign mem_addr = addr_q;
  assign IR       = ir_q;
  assign PC       = pc_cur;
  assign halted   = halted_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory/execute responders, a scoreboard
// of expected IL deliveries, table-driven fetch vectors and hand-written corner sequences.
module tb_instruction_fetch_unit;

  localparam int TIMEOUT  = 15;
  localparam int ACK_LAT  = 2;
  localparam int EXEC_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, exec_done, pc_load, mem_ack, mem_req, IL, halted, fault;
  logic [7:0]  pc_in, mem_addr, PC;
  logic [15:0] mem_data, IR;

  logic        run_w, exec_done_w, pc_load_w, mem_ack_w, mem_req_w, IL_w, halted_w, fault_w;
  logic [7:0]  pc_in_w, mem_addr_w, PC_w;
  logic [15:0] mem_data_w, IR_w;

  instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .TIMEOUT(TIMEOUT), .HALT_OP(4'hF)) u_dut (
    .clk(clk), .reset(reset), .run(run), .exec_done(exec_done), .pc_load(pc_load), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .IR(IR), .IL(IL), .PC(PC), .halted(halted), .fault(fault));

  instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF), .TIMEOUT(TIMEOUT), .HALT_OP(4'hF)) u_dut_w (
    .clk(clk), .reset(reset), .run(run_w), .exec_done(exec_done_w), .pc_load(pc_load_w), .pc_in(pc_in_w),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_data(mem_data_w),
    .IR(IR_w), .IL(IL_w), .PC(PC_w), .halted(halted_w), .fault(fault_w));

  typedef struct packed {logic [15:0] ir; logic [7:0] pc;} sb_t;
  typedef struct packed {logic [7:0] addr; logic [15:0] ir; logic [7:0] pc;} vec_t;

  sb_t         sb_q[$];
  logic [15:0] mem [256];
  int          errors = 0;
  int          checks = 0;
  int          mem_cnt, exec_cnt, il_cnt, discard_acks, gap_cnt;
  bit          ack_en, discard, branch_armed, flush_armed, flush_win, prev_il, prev_req_hold;
  logic [7:0]  branch_tgt, flush_at, flush_tgt, last_ack_addr, prev_addr;
  logic [7:0]  w_addrs[$];
  bit          w_rec, w_il_seen;
  logic [15:0] w_ir_first;
  logic [7:0]  w_pc_first;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample DUT outputs at the falling edge, then drive inputs for the next rise.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    pc_load   = 1'b0;
    exec_done = 1'b0;
    if (mem_req && prev_req_hold) check("addr_stable", mem_addr, prev_addr);
    if (exec_cnt > 0) begin
      exec_cnt--;
      if (exec_cnt == 0) begin
        exec_done = 1'b1;
        if (branch_armed) begin
          pc_load      = 1'b1;
          pc_in        = branch_tgt;
          branch_armed = 1'b0;
        end
      end
    end
    if (IL) begin
      check("il_consecutive", prev_il, 0);
      il_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_il: IR=%h with no expected word", IR);
      end else begin
        e = sb_q.pop_front();
        check("sb_ir", IR, e.ir);
        check("sb_pc", PC, e.pc);
      end
      exec_cnt  = EXEC_LAT;
      flush_win = 1'b0;
    end
    prev_il = IL;
    // memory responder: ack ACK_LAT cycles after the request is first seen
    if (mem_ack) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (mem_req && ack_en) begin
      if (mem_cnt == ACK_LAT) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        mem_cnt  = 0;
        if (discard) begin
          discard = 1'b0;
          discard_acks++;
        end else begin
          sb_q.push_back({mem[mem_addr], mem_addr + 8'd1});
          last_ack_addr = mem_addr;
        end
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    if (flush_armed && mem_req && !mem_ack && mem_addr == flush_at && mem_cnt == 1) begin
      pc_load     = 1'b1;
      pc_in       = flush_tgt;
      flush_armed = 1'b0;
      discard     = 1'b1;
      flush_win   = 1'b1;
      gap_cnt     = 0;
    end
    if (flush_win && !mem_req) gap_cnt++;
    prev_req_hold = mem_req && !mem_ack;
    prev_addr     = mem_addr;
    // wraparound instance: instant ack, instant exec_done
    mem_ack_w  = mem_req_w;
    mem_data_w = {8'hA5, mem_addr_w};
    if (mem_req_w && w_rec && w_addrs.size() < 3) w_addrs.push_back(mem_addr_w);
    if (IL_w && w_rec && !w_il_seen) begin
      w_il_seen  = 1'b1;
      w_ir_first = IR_w;
      w_pc_first = PC_w;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    mem_ack = 1'b0;
    ack_en = 1'b1;
    sb_q.delete();
    mem_cnt = 0;
    exec_cnt = 0;
    il_cnt = 0;
    discard = 1'b0;
    discard_acks = 0;
    gap_cnt = 0;
    branch_armed = 1'b0;
    flush_armed = 1'b0;
    flush_win = 1'b0;
    prev_il = 1'b0;
    prev_req_hold = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_il(input string name);
    int start;
    start = il_cnt;
    for (int i = 0; i < 60 && il_cnt == start; i++) tick();
    check({name, "_il_seen"}, (il_cnt != start), 1);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    wait_il(tag);
    check({tag, "_addr"}, last_ack_addr, v.addr);
    check({tag, "_ir"}, IR, v.ir);
    check({tag, "_pc"}, PC, v.pc);
  endtask

  initial begin
    vec_t va[3];
    vec_t vb[2];
    vec_t vc[2];
    int   n;
    bit   req_seen;
    va = '{'{8'h00, 16'h8006, 8'h01}, '{8'h01, 16'h1234, 8'h02}, '{8'h02, 16'hF000, 8'h03}};
    vb = '{'{8'h00, 16'h8006, 8'h01}, '{8'h40, 16'h2222, 8'h41}};
    vc = '{'{8'h00, 16'h8006, 8'h01}, '{8'h10, 16'h3333, 8'h11}};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    mem[8'h00] = 16'h8006;
    mem[8'h01] = 16'h1234;
    mem[8'h02] = 16'hF000;
    mem[8'h10] = 16'h3333;
    mem[8'h40] = 16'h2222;
    exec_done = 1'b0; pc_load = 1'b0; pc_in = 8'h00; mem_data = 16'h0000;
    run_w = 1'b1; exec_done_w = 1'b1; pc_load_w = 1'b0; pc_in_w = 8'h00;
    mem_ack_w = 1'b0; mem_data_w = 16'h0000;
    w_rec = 1'b0; w_il_seen = 1'b0; w_ir_first = 16'h0; w_pc_first = 8'h0;
    last_ack_addr = 8'h00; prev_addr = 8'h00; branch_tgt = 8'h00;
    flush_at = 8'h00; flush_tgt = 8'h00;

    // Run A: sequential fetch, HALT opcode, pc_load ignored in HALT
    do_reset();
    check("rst_pc", PC, 8'h00);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_ir", IR, 16'h0000);
    check("rst_il", IL, 0);
    check("rst_req", mem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("w_rst_pc", PC_w, 8'hFF);
    check("w_rst_addr", mem_addr_w, 8'hFF);
    w_rec = 1'b1;
    reset = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 3; i++) check_vec($sformatf("A%0d", i), va[i]);
    branch_armed = 1'b1;
    branch_tgt = 8'h55;
    tick();
    check("A_halted", halted, 1);
    req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req) req_seen = 1'b1;
    end
    check("A_halt_no_req", req_seen, 0);
    check("A_halt_pc_held", PC, 8'h03);
    check("A_il_count", il_cnt, 3);
    check("A_fault", fault, 0);

    // Wraparound instance from RESET_PC=FF
    check("W_fetch_count", (w_addrs.size() >= 3), 1);
    if (w_addrs.size() >= 3) begin
      check("W_addr0", w_addrs[0], 8'hFF);
      check("W_addr1", w_addrs[1], 8'h00);
      check("W_addr2", w_addrs[2], 8'h01);
    end
    check("W_first_ir", w_ir_first, 16'hA5FF);
    check("W_pc_wrap", w_pc_first, 8'h00);
    w_rec = 1'b0;

    // Run B: branch together with exec_done, then run=0 returns to IDLE
    do_reset();
    branch_armed = 1'b1;
    branch_tgt = 8'h40;
    reset = 1'b0;
    run = 1'b1;
    check_vec("B0", vb[0]);
    check_vec("B1", vb[1]);
    run = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_req) req_seen = 1'b1;
    end
    check("B_idle_no_req", req_seen, 0);
    check("B_pc_idle", PC, 8'h41);
    check("B_halted", halted, 0);

    // Run C: flush while request to addr 1 outstanding, then memory timeout and reset
    do_reset();
    flush_armed = 1'b1;
    flush_at = 8'h01;
    flush_tgt = 8'h10;
    reset = 1'b0;
    run = 1'b1;
    check_vec("C0", vc[0]);
    check_vec("C1", vc[1]);
    ack_en = 1'b0;
    check("C_discarded_acks", discard_acks, 1);
    check("C_req_gap", gap_cnt, 0);
    check("C_il_count", il_cnt, 2);
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    check("T_req_started", mem_req, 1);
    check("T_addr", mem_addr, 8'h11);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    check("T_req_cycles", n, TIMEOUT);
    check("T_fault", fault, 1);
    check("T_req_dropped", mem_req, 0);
    check("T_halted", halted, 0);
    reset = 1'b1;
    tick();
    check("R_fault", fault, 0);
    check("R_pc", PC, 8'h00);
    check("R_ir", IR, 16'h0000);
    check("R_il", IL, 0);
    check("R_req", mem_req, 0);
    reset = 1'b0;
    ack_en = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
